// File: rtl/rr_pop_arbiter_pkg.sv
// Shared definitions for the round-robin pop arbiter in front of the 4x4 crossbar.
package rr_pop_arbiter_pkg;
  localparam int NPORTS  = 4;
  localparam int DATA_W  = 10;
  localparam int DEST_HI = 9;
  localparam int DEST_LO = 8;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, SERVE = 2'd2} state_t;

  // One arbitration decision: whether anything was granted, and to which input.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } grant_t;

  // Destination output port carried in the head word.
  function automatic logic [IDX_W-1:0] dest_of(input logic [DATA_W-1:0] w);
    return w[DEST_HI:DEST_LO];
  endfunction
endpackage

// File: rtl/rr_pop_arbiter_pick4.sv
// Rotate-priority finder: first set bit of req scanning start, start+1, ... (mod 4).
module rr_pick4
  import rr_pop_arbiter_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  start,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is the last (winning) write.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      cand = start + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/rr_pop_arbiter.sv
// Round-robin arbiter: picks at most one input FIFO per cycle, pops it, pushes the
// destination output FIFO and steers the crossbar. Grant is zero-latency from state.
module rr_pop_arbiter
  import rr_pop_arbiter_pkg::*;
#(
  parameter int MAX_BURST   = 4,
  parameter int INIT_CYCLES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  fifo0_out,
  input  logic [DATA_W-1:0]  fifo1_out,
  input  logic [DATA_W-1:0]  fifo2_out,
  input  logic [DATA_W-1:0]  fifo3_out,
  input  logic [NPORTS-1:0]  fifo_empty,
  input  logic [NPORTS-1:0]  almost_full,
  output logic [NPORTS-1:0]  pop,
  output logic [NPORTS-1:0]  push,
  output logic [IDX_W-1:0]   demux0,
  output logic [COUNT_W-1:0] pkt_cnt4,
  output logic [COUNT_W-1:0] pkt_cnt5,
  output logic [COUNT_W-1:0] pkt_cnt6,
  output logic [COUNT_W-1:0] pkt_cnt7,
  output logic               idle
);
  logic [NPORTS-1:0][DATA_W-1:0]  head;
  logic [NPORTS-1:0]              elig;
  logic [NPORTS-1:0][COUNT_W-1:0] pkt_cnt;

  state_t           state;
  logic [3:0]       init_cnt;
  logic [3:0]       burst_cnt;
  logic [IDX_W-1:0] ptr, owner, last_sel;

  logic             idle_found, serve_found;
  logic [IDX_W-1:0] idle_idx, serve_idx;
  logic             owner_cont;
  grant_t           gnt;
  logic [IDX_W-1:0] gnt_dest;

  assign head = {fifo3_out, fifo2_out, fifo1_out, fifo0_out};

  // An input competes only if it has data and its head's destination can accept it,
  // so a blocked head never stalls the other inputs.
  for (genvar i = 0; i < NPORTS; i++) begin : g_elig
    assign elig[i] = !fifo_empty[i] && !almost_full[dest_of(head[i])];
  end

  rr_pick4 u_pick_idle (
    .req   (elig),
    .start (ptr),
    .found (idle_found),
    .idx   (idle_idx)
  );

  // Starting one past the owner leaves the owner as the last candidate.
  rr_pick4 u_pick_serve (
    .req   (elig),
    .start (owner + 2'd1),
    .found (serve_found),
    .idx   (serve_idx)
  );

  assign owner_cont = (state == SERVE) && elig[owner] && (burst_cnt < 4'(MAX_BURST));

  // Arbitration decision for this cycle from registered state and live inputs.
  always_comb begin
    gnt = '0;
    case (state)
      IDLE: begin
        gnt.vld = idle_found;
        gnt.idx = idle_idx;
      end
      SERVE: begin
        if (owner_cont) begin
          gnt.vld = 1'b1;
          gnt.idx = owner;
        end else begin
          gnt.vld = serve_found;
          gnt.idx = serve_idx;
        end
      end
      default: gnt = '0;
    endcase
  end

  assign gnt_dest = dest_of(head[gnt.idx]);
  assign pop      = gnt.vld ? (NPORTS'(1) << gnt.idx)  : '0;
  assign push     = gnt.vld ? (NPORTS'(1) << gnt_dest) : '0;
  // Hold the crossbar select between grants so it does not toggle needlessly.
  assign demux0   = gnt.vld ? gnt.idx : last_sel;
  assign idle     = (state == IDLE) && (&fifo_empty);

  // Arbiter FSM: startup quiet period, idle search, and bursting service.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      last_sel  <= '0;
    end else begin
      if (gnt.vld) last_sel <= gnt.idx;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 4'd1;
          if (init_cnt == 4'(INIT_CYCLES - 1)) state <= IDLE;
        end
        IDLE: begin
          if (gnt.vld) begin
            owner     <= gnt.idx;
            burst_cnt <= 4'd1;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (owner_cont) begin
            burst_cnt <= burst_cnt + 4'd1;
          end else if (gnt.vld) begin
            owner     <= gnt.idx;
            burst_cnt <= 4'd1;
          end else begin
            ptr   <= owner + 2'd1;
            state <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Per-destination packet counters, free-running modulo 2^COUNT_W.
  for (genvar j = 0; j < NPORTS; j++) begin : g_cnt
    always_ff @(posedge clk or posedge reset) begin
      if (reset)        pkt_cnt[j] <= '0;
      else if (push[j]) pkt_cnt[j] <= pkt_cnt[j] + COUNT_W'(1);
    end
  end

  assign pkt_cnt4 = pkt_cnt[0];
  assign pkt_cnt5 = pkt_cnt[1];
  assign pkt_cnt6 = pkt_cnt[2];
  assign pkt_cnt7 = pkt_cnt[3];
endmodule

// File: tb/tb_rr_pop_arbiter.sv
// Self-checking bench for rr_pop_arbiter: behavioural model plus directed literals.
module tb_rr_pop_arbiter;
  localparam int MAX_BURST   = 4;
  localparam int INIT_CYCLES = 2;
  localparam int COUNT_W     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] fifo0_out = '0, fifo1_out = '0, fifo2_out = '0, fifo3_out = '0;
  logic [3:0] fifo_empty = 4'hF, almost_full = '0;
  logic [3:0] pop, push;
  logic [1:0] demux0;
  logic [COUNT_W-1:0] pkt_cnt4, pkt_cnt5, pkt_cnt6, pkt_cnt7;
  logic       idle;

  int n_vec = 0;
  int n_err = 0;

  rr_pop_arbiter #(.MAX_BURST(MAX_BURST), .INIT_CYCLES(INIT_CYCLES), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset),
    .fifo0_out(fifo0_out), .fifo1_out(fifo1_out), .fifo2_out(fifo2_out), .fifo3_out(fifo3_out),
    .fifo_empty(fifo_empty), .almost_full(almost_full),
    .pop(pop), .push(push), .demux0(demux0),
    .pkt_cnt4(pkt_cnt4), .pkt_cnt5(pkt_cnt5), .pkt_cnt6(pkt_cnt6), .pkt_cnt7(pkt_cnt7),
    .idle(idle)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 = startup quiet period, 1 = idle, 2 = serving an owner
  int m_mode, m_init, m_ptr, m_owner, m_burst, m_last;
  int m_pkt[4];
  // per-cycle decision
  bit m_gnt, m_cont;
  int m_win;

  function automatic int dest(int i);
    case (i)
      0: return int'(fifo0_out[9:8]);
      1: return int'(fifo1_out[9:8]);
      2: return int'(fifo2_out[9:8]);
      default: return int'(fifo3_out[9:8]);
    endcase
  endfunction

  function automatic bit eligible(int i);
    return !fifo_empty[i] && !almost_full[dest(i)];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_init = 0; m_ptr = 0; m_owner = 0; m_burst = 0; m_last = 0;
    foreach (m_pkt[j]) m_pkt[j] = 0;
  endtask

  task automatic model_eval();
    m_gnt = 0; m_cont = 0; m_win = 0;
    if (m_mode == 1) begin
      for (int k = 0; k < 4 && !m_gnt; k++)
        if (eligible((m_ptr + k) % 4)) begin m_gnt = 1; m_win = (m_ptr + k) % 4; end
    end else if (m_mode == 2) begin
      if (eligible(m_owner) && m_burst < MAX_BURST) begin
        m_gnt = 1; m_cont = 1; m_win = m_owner;
      end else begin
        for (int k = 1; k <= 4 && !m_gnt; k++)
          if (eligible((m_owner + k) % 4)) begin m_gnt = 1; m_win = (m_owner + k) % 4; end
      end
    end
  endtask

  task automatic model_update();
    if (m_gnt) begin
      m_pkt[dest(m_win)] = (m_pkt[dest(m_win)] + 1) % (1 << COUNT_W);
      m_last = m_win;
    end
    case (m_mode)
      0: begin
        if (m_init == INIT_CYCLES - 1) m_mode = 1;
        m_init++;
      end
      1: if (m_gnt) begin m_owner = m_win; m_burst = 1; m_mode = 2; end
      default: begin
        if (m_cont) m_burst++;
        else if (m_gnt) begin m_owner = m_win; m_burst = 1; end
        else begin m_ptr = (m_owner + 1) % 4; m_mode = 1; end
      end
    endcase
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic sample();
    logic [3:0] e_pop, e_push;
    #1;
    if (reset) model_reset();
    model_eval();
    e_pop  = m_gnt ? 4'(1 << m_win) : 4'd0;
    e_push = m_gnt ? 4'(1 << dest(m_win)) : 4'd0;
    chk("pop",    32'(pop),    32'(e_pop));
    chk("push",   32'(push),   32'(e_push));
    chk("demux0", 32'(demux0), 32'(m_gnt ? m_win : m_last));
    chk("idle",   32'(idle),   32'((m_mode == 1) && (fifo_empty == 4'hF)));
    chk("pkt_cnt4", 32'(pkt_cnt4), 32'(m_pkt[0]));
    chk("pkt_cnt5", 32'(pkt_cnt5), 32'(m_pkt[1]));
    chk("pkt_cnt6", 32'(pkt_cnt6), 32'(m_pkt[2]));
    chk("pkt_cnt7", 32'(pkt_cnt7), 32'(m_pkt[3]));
  endtask

  // Clock edge: update the model alongside the DUT, return at the next falling edge.
  task automatic advance();
    @(posedge clk);
    if (!reset) model_update();
    @(negedge clk);
  endtask

  task automatic set_heads(int d0, int d1, int d2, int d3);
    fifo0_out = {2'(d0), 8'h10};
    fifo1_out = {2'(d1), 8'h21};
    fifo2_out = {2'(d2), 8'h32};
    fifo3_out = {2'(d3), 8'h43};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample();
    chk("rst_pop",  32'(pop),    32'd0);
    chk("rst_push", 32'(push),   32'd0);
    chk("rst_dmx",  32'(demux0), 32'd0);
    chk("rst_idle", 32'(idle),   32'd0);
    advance();
    sample();
    advance();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Startup: all inputs have data for output 4; nothing granted during INIT.
    do_reset();
    set_heads(0, 0, 0, 0); fifo_empty = 4'b0000; almost_full = 4'b0000;
    for (int c = 0; c < INIT_CYCLES; c++) begin
      sample(); chk("init_pop", 32'(pop), 32'd0); advance();
    end
    sample();
    chk("first_pop",  32'(pop),    32'b0001);
    chk("first_push", 32'(push),   32'b0001);
    chk("first_dmx",  32'(demux0), 32'd0);
    advance();

    // Bursting: inputs 0 and 1 to output 5, four grants each alternating.
    do_reset();
    set_heads(1, 1, 1, 1); fifo_empty = 4'b1100;
    for (int c = 0; c < INIT_CYCLES; c++) begin sample(); advance(); end
    for (int k = 0; k < 16; k++) begin
      sample();
      chk("burst_pop",  32'(pop), ((k / 4) % 2) ? 32'b0010 : 32'b0001);
      chk("burst_cnt5", 32'(pkt_cnt5), 32'(k));
      advance();
    end

    // Blocked head: input 0 aims at almost-full output 6, input 3 still served.
    set_heads(2, 0, 0, 3); fifo_empty = 4'b0110; almost_full = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("hol_pop",  32'(pop),    32'b1000);
      chk("hol_push", 32'(push),   32'b1000);
      chk("hol_dmx",  32'(demux0), 32'd3);
      advance();
    end

    // All empty: no grants, select held at the last grant, idle once back in IDLE.
    fifo_empty = 4'b1111; almost_full = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("empty_pop", 32'(pop),    32'd0);
      chk("empty_dmx", 32'(demux0), 32'd3);
      if (k == 2) chk("empty_idle", 32'(idle), 32'd1);
      advance();
    end

    // Counter wrap: 300 back-to-back grants to output 4.
    do_reset();
    set_heads(0, 0, 0, 0); fifo_empty = 4'b1110;
    for (int c = 0; c < INIT_CYCLES + 300; c++) begin sample(); advance(); end
    sample();
    chk("wrap_cnt4", 32'(pkt_cnt4), 32'd44);
    advance();

    // Reset in the middle of a burst, then a clean restart from input 0.
    do_reset();
    set_heads(0, 0, 0, 0); fifo_empty = 4'b1010;
    for (int c = 0; c < INIT_CYCLES + 2; c++) begin sample(); advance(); end
    reset = 1'b1;
    sample();
    chk("mid_pop",  32'(pop),      32'd0);
    chk("mid_push", 32'(push),     32'd0);
    chk("mid_cnt4", 32'(pkt_cnt4), 32'd0);
    advance();
    reset = 1'b0;
    for (int c = 0; c < INIT_CYCLES; c++) begin
      sample(); chk("reinit_pop", 32'(pop), 32'd0); advance();
    end
    sample();
    chk("restart_pop", 32'(pop), 32'b0001);
    advance();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      set_heads($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      fifo_empty = (c % 500 < 250) ? 4'($urandom) & 4'($urandom) : 4'($urandom);
      almost_full = 4'($urandom) & 4'($urandom) & 4'($urandom);
      sample();
      advance();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
